// File: rtl/fifo_beat_unpacker.sv
// Pops one wide FIFO entry at a time and replays it as 1..BEATS narrow beats
// over a valid/ready handshake, with back-to-back pops and no bubbles.
module fifo_beat_unpacker #(
    parameter int BEAT_WIDTH = 32,
    parameter int BEATS      = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             flush,
    input  logic                                             fifo_valid,
    input  logic [$clog2(BEATS)+BEATS*BEAT_WIDTH-1:0]        fifo_data,
    output logic                                             fifo_pop,
    output logic                                             beat_valid,
    input  logic                                             beat_ready,
    output logic [BEAT_WIDTH-1:0]                            beat_data,
    output logic                                             beat_last,
    output logic                                             busy
);
    localparam int LEN_W       = $clog2(BEATS);
    localparam int DATA_W      = BEATS * BEAT_WIDTH;
    localparam int ENTRY_WIDTH = LEN_W + DATA_W;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                        state, state_n;
    logic [LEN_W-1:0]              idx, idx_n;
    logic [LEN_W-1:0]              hold_len, hold_len_n;
    logic [DATA_W-1:0]             hold_data, hold_data_n;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] beats;
    logic                          hold_valid;
    logic                          accept;
    logic                          done;

    assign hold_valid = (state == DRAIN);
    assign beats      = hold_data;

    assign beat_valid = hold_valid;
    assign beat_data  = beats[idx];
    assign beat_last  = hold_valid & (idx == hold_len);
    assign busy       = hold_valid;

    assign accept = beat_valid & beat_ready;
    assign done   = accept & beat_last;

    // Combinational pop lets the producer refill a full FIFO in the pop cycle.
    assign fifo_pop = fifo_valid & ~flush & ~rst & (~hold_valid | done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            idx       <= '0;
            hold_len  <= '0;
            hold_data <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hold_len  <= hold_len_n;
            hold_data <= hold_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        hold_len_n  = hold_len;
        hold_data_n = hold_data;
        if (flush) begin
            // A same-cycle accept still lands at the sink; nothing follows it.
            state_n = EMPTY;
            idx_n   = '0;
        end else if (fifo_pop) begin
            state_n     = DRAIN;
            idx_n       = '0;
            hold_len_n  = fifo_data[ENTRY_WIDTH-1 -: LEN_W];
            hold_data_n = fifo_data[DATA_W-1:0];
        end else if (accept && !beat_last) begin
            idx_n = idx + LEN_W'(1);
        end else if (done) begin
            state_n = EMPTY;
        end
    end

    generate
        if ((1 << LEN_W) != BEATS) begin : g_len_chk
            // Length codes past the last beat slot have no backing data.
            always_ff @(posedge clk) begin
                if (!rst && fifo_pop)
                    assert (fifo_data[ENTRY_WIDTH-1 -: LEN_W] <= LEN_W'(BEATS - 1));
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_beat_unpacker.sv
// Random traffic through a depth-2 FIFO model into fifo_beat_unpacker; a
// scoreboard of expected beats is checked by a negedge monitor.
module tb_fifo_beat_unpacker;
    localparam int BW    = 32;
    localparam int BEATS = 4;
    localparam int LEN_W = 2;
    localparam int EW    = LEN_W + BEATS * BW;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          fifo_valid = 1'b0;
    logic [EW-1:0] fifo_data = '0;
    logic          fifo_pop;
    logic          beat_valid;
    logic          beat_ready = 1'b0;
    logic [BW-1:0] beat_data;
    logic          beat_last;
    logic          busy;

    fifo_beat_unpacker #(.BEAT_WIDTH(BW), .BEATS(BEATS)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_data  (beat_data),
        .beat_last  (beat_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [EW-1:0] fifo_q[$];
    logic [EW-1:0] sent_q[$];
    int            vectors = 0;
    int            errors  = 0;
    bit            prev_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int len, input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                                         input logic [BW-1:0] b2, input logic [BW-1:0] b3);
        return {LEN_W'(len), b3, b2, b1, b0};
    endfunction

    function automatic logic [EW-1:0] rnd_entry();
        return mk($urandom_range(0, BEATS - 1), $urandom, $urandom, $urandom, $urandom);
    endfunction

    task automatic push_entry(input logic [EW-1:0] e);
        fifo_q.push_back(e);
        sent_q.push_back(e);
    endtask

    task automatic refresh_fifo();
        fifo_valid = (fifo_q.size() > 0);
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    // Reference: each popped entry contributes len+1 beats; only the final one is last.
    always @(negedge clk) begin
        logic exp_pop;
        logic exp_last;
        logic [EW-1:0] e;
        int len;
        exp_last = (exp_q.size() > 0) ? exp_q[0].last : 1'b0;
        exp_pop  = fifo_valid && !flush && !rst &&
                   (exp_q.size() == 0 || (beat_ready && exp_q[0].last));
        chk("beat_valid", 64'(beat_valid), 64'(exp_q.size() > 0));
        chk("busy", 64'(busy), 64'(exp_q.size() > 0));
        chk("beat_last", 64'(beat_last), 64'(exp_last));
        chk("fifo_pop", 64'(fifo_pop), 64'(exp_pop));
        if (exp_q.size() > 0) chk("beat_data", 64'(beat_data), 64'(exp_q[0].d));
        if (prev_rst && !rst) chk("reset_beat_data", 64'(beat_data), 64'(0));
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && beat_ready) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            if (fifo_pop && sent_q.size() > 0) begin
                e   = sent_q.pop_front();
                len = int'(e[EW-1 -: LEN_W]);
                for (int k = 0; k <= len; k++) exp_q.push_back('{d: e[k*BW +: BW], last: (k == len)});
            end
        end
        prev_rst = rst;
    end

    initial begin
        bit            do_pop;
        bit            do_push;
        logic [EW-1:0] nxt;
        int            guard;
        // Two directed entries sit at the head while reset is held.
        push_entry(mk(3, 32'h11, 32'h22, 32'h33, 32'h44));
        push_entry(mk(1, 32'hA0, 32'hA1, 32'h0, 32'h0));
        refresh_fifo();
        beat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            do_pop  = fifo_pop;
            do_push = (fifo_q.size() < DEPTH || do_pop) && ($urandom_range(0, 3) != 0);
            nxt     = (c == 0) ? mk(0, 32'hB0, 32'h0, 32'h0, 32'h0) : rnd_entry();
            @(posedge clk);
            #1;
            if (do_pop) void'(fifo_q.pop_front());
            if (do_push) push_entry(nxt);
            chk("fifo_no_overflow", 64'(fifo_q.size() <= DEPTH), 64'(1));
            refresh_fifo();
            beat_ready = (c < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            flush      = (c > 20) && ($urandom_range(0, 24) == 0);
        end

        flush      = 1'b0;
        beat_ready = 1'b1;
        guard      = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && guard < 200) begin
            @(negedge clk);
            #1;
            do_pop = fifo_pop;
            @(posedge clk);
            #1;
            if (do_pop) void'(fifo_q.pop_front());
            refresh_fifo();
            guard++;
        end
        @(negedge clk);
        #1;
        chk("drain_fifo_empty", 64'(fifo_q.size()), 64'(0));
        chk("drain_beats_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_idle", 64'(busy), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
